// File: rtl/pixel_denormalizer.sv
// pixel_denormalizer
//   Turns a screen-space pixel plus depth back into a homogeneous NDC point
//   (x, y, z, w) in signed Q(CORDW-FRAC).FRAC fixed point. Picking/readback
//   logic uses it to feed a pixel back through the transform pipeline.
//
//   x = (pixel_x - SCREEN_W/2) / (SCREEN_W/2)
//   y = (SCREEN_H/2 - pixel_y) / (SCREEN_H/2)
//   z = depth
//   w = 1.0
//
//   X and Y share one restoring divider (one quotient bit per clock). The
//   divide works on magnitudes and the sign is applied afterwards, so the
//   result truncates toward zero.
//
//   Optional feature macro: DENORM_ROUND_EN
//     defined   : half the divisor is added to the numerator first, so the
//                 quotient rounds half away from zero (same latency)
//     undefined : truncate toward zero
//
// Ports
//   clock, reset            clock, synchronous active-high reset
//   io_in_valid/io_in_ready request handshake (ready only when idle)
//   io_pixel_x, io_pixel_y  unsigned pixel column/row
//   io_depth                signed depth, passed through to z
//   io_out_valid/ready      result handshake; outputs held while stalled
//   io_point_x/y/z/w        signed point components
//   io_out_oob              pixel lay outside the screen rectangle
//
// Latency: io_out_valid rises 2*DIVW+1 edges after the accepting edge.

module pixel_denormalizer #(
  parameter int CORDW    = 16,
  parameter int FRAC     = 8,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic [CORDW-1:0]        io_pixel_x,
  input  logic [CORDW-1:0]        io_pixel_y,
  input  logic [CORDW-1:0]        io_depth,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic signed [CORDW-1:0] io_point_x,
  output logic signed [CORDW-1:0] io_point_y,
  output logic signed [CORDW-1:0] io_point_z,
  output logic signed [CORDW-1:0] io_point_w,
  output logic                    io_out_oob
);

  localparam int DIVW = CORDW + FRAC;
  localparam int NW   = CORDW + 1;
  localparam int CW   = $clog2(DIVW + 1);

  localparam logic [NW-1:0] HALF_W = NW'(SCREEN_W / 2);
  localparam logic [NW-1:0] HALF_H = NW'(SCREEN_H / 2);
`ifdef DENORM_ROUND_EN
  localparam logic [DIVW-1:0] BIAS_W = DIVW'(SCREEN_W / 4);
  localparam logic [DIVW-1:0] BIAS_H = DIVW'(SCREEN_H / 4);
`else
  localparam logic [DIVW-1:0] BIAS_W = '0;
  localparam logic [DIVW-1:0] BIAS_H = '0;
`endif
  localparam logic signed [CORDW-1:0] ONE = CORDW'(1 << FRAC);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIVW - 1);
  localparam logic [CW-1:0] FINAL_CNT = CW'(DIVW);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]           cnt;
  logic                    nx_neg;
  logic signed [NW-1:0]    ny;
  logic [CORDW-1:0]        depth_lat;
  logic                    oob_lat;
  logic [CORDW-1:0]        qx;
  logic [DIVW-1:0]         quo;
  logic [NW-1:0]           rem;

  logic signed [NW-1:0]    nx_in;
  logic signed [NW-1:0]    ny_in;
  logic                    oob_in;
  logic [NW-1:0]           divisor;
  logic [NW-1:0]           shifted;
  logic                    qbit;
  logic [NW-1:0]           rem_next;
  logic [DIVW-1:0]         quo_next;
  logic                    accept;

  // Magnitude numerator |n| << FRAC, plus the optional rounding bias.
  function automatic logic [DIVW-1:0] mag_num(input logic signed [NW-1:0] n,
                                               input logic [DIVW-1:0] bias);
    logic [CORDW-1:0] m;
    m = n[NW-1] ? CORDW'(-n) : CORDW'(n);
    return {m, {FRAC{1'b0}}} + bias;
  endfunction

  // Apply the sign of the original offset to the truncated quotient.
  function automatic logic signed [CORDW-1:0] apply_sign(input logic [CORDW-1:0] q,
                                                         input logic neg);
    logic [CORDW-1:0] r;
    r = neg ? (~q + 1'b1) : q;
    return $signed(r);
  endfunction

  assign accept       = io_in_valid && (state == IDLE);
  assign io_in_ready  = (state == IDLE);
  assign io_out_valid = (state == DONE);

  assign nx_in  = $signed({1'b0, io_pixel_x}) - $signed(HALF_W);
  assign ny_in  = $signed(HALF_H) - $signed({1'b0, io_pixel_y});
  assign oob_in = (io_pixel_x >= CORDW'(SCREEN_W)) || (io_pixel_y >= CORDW'(SCREEN_H));

  // One restoring-divide step: the numerator shifts out of quo's MSB into
  // the partial remainder while quotient bits shift in at quo's LSB.
  always_comb begin
    divisor  = (state == DIV_Y) ? HALF_H : HALF_W;
    shifted  = {rem[NW-2:0], quo[DIVW-1]};
    qbit     = (shifted >= divisor);
    rem_next = qbit ? (shifted - divisor) : shifted;
    quo_next = {quo[DIVW-2:0], qbit};
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (io_in_valid)       state_next = DIV_X;
      DIV_X:   if (cnt == LAST_STEP)  state_next = DIV_Y;
      // DIV_Y spends one extra cycle after the last step applying signs
      // and registering the outputs.
      DIV_Y:   if (cnt == FINAL_CNT)  state_next = DONE;
      DONE:    if (io_out_ready)      state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Step counter and output registers (reset).
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      io_point_x <= '0;
      io_point_y <= '0;
      io_point_z <= '0;
      io_point_w <= '0;
      io_out_oob <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) cnt <= '0;
        DIV_X: cnt <= (cnt == LAST_STEP) ? '0 : cnt + 1'b1;
        DIV_Y: begin
          if (cnt == FINAL_CNT) begin
            io_point_x <= apply_sign(qx, nx_neg);
            io_point_y <= apply_sign(quo[CORDW-1:0], ny[NW-1]);
            io_point_z <= $signed(depth_lat);
            io_point_w <= ONE;
            io_out_oob <= oob_lat;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Divider datapath (no reset needed: always loaded on acceptance).
  always_ff @(posedge clock) begin
    case (state)
      IDLE: begin
        if (accept) begin
          nx_neg    <= nx_in[NW-1];
          ny        <= ny_in;
          depth_lat <= io_depth;
          oob_lat   <= oob_in;
          quo       <= mag_num(nx_in, BIAS_W);
          rem       <= '0;
        end
      end
      DIV_X: begin
        if (cnt == LAST_STEP) begin
          qx  <= quo_next[CORDW-1:0];
          quo <= mag_num(ny, BIAS_H);
          rem <= '0;
        end else begin
          quo <= quo_next;
          rem <= rem_next;
        end
      end
      DIV_Y: begin
        if (cnt != FINAL_CNT) begin
          quo <= quo_next;
          rem <= rem_next;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pixel_denormalizer.sv
// Self-checking bench for pixel_denormalizer: directed table, stall and
// mid-divide reset sequences, then random requests against a plain
// arithmetic reference model.
module tb_pixel_denormalizer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [15:0] io_pixel_x = '0;
  logic [15:0] io_pixel_y = '0;
  logic [15:0] io_depth = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic signed [15:0] io_point_x, io_point_y, io_point_z, io_point_w;
  logic        io_out_oob;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_denormalizer dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_pixel_x(io_pixel_x), .io_pixel_y(io_pixel_y), .io_depth(io_depth),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_point_x(io_point_x), .io_point_y(io_point_y),
    .io_point_z(io_point_z), .io_point_w(io_point_w),
    .io_out_oob(io_out_oob)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: offset from screen centre divided by the half extent,
  // in FRAC=8 fixed point, sign applied to the magnitude quotient.
  function automatic logic [15:0] model_axis(input int offset, input int half);
    int mag, q, r;
    mag = (offset < 0 ? -offset : offset) * 256;
`ifdef DENORM_ROUND_EN
    mag = mag + half / 2;
`endif
    q = mag / half;
    r = (offset < 0) ? -q : q;
    return r[15:0];
  endfunction

  // Issue one request and check the full transaction. hold>0 stalls the
  // consumer in DONE for that many cycles while offering a bogus request.
  task automatic run(input int x, input int y, input int d,
                     input logic [15:0] ex, input logic [15:0] ey,
                     input logic eoob, input int hold);
    int edges;
    bit busy_ok, stable_ok;
    logic [15:0] sx, sy, sz, sw;
    logic so;
    check("in_ready_idle", io_in_ready, 1);
    io_pixel_x  = 16'(x);
    io_pixel_y  = 16'(y);
    io_depth    = 16'(d);
    io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    io_pixel_x  = 16'($urandom);
    io_pixel_y  = 16'($urandom);
    io_depth    = 16'($urandom);
    edges = 0;
    busy_ok = 1;
    while (!io_out_valid && edges < 120) begin
      if (io_in_ready) busy_ok = 0;
      if (edges == 5) io_in_valid = 1'b1;  // ignored while busy
      @(posedge clock); #1;
      edges++;
    end
    io_in_valid = 1'b0;
    check("latency", edges, 49);
    check("in_ready_busy", busy_ok, 1);
    check("point_x", io_point_x, $signed(ex));
    check("point_y", io_point_y, $signed(ey));
    check("point_z", io_point_z, $signed(16'(d)));
    check("point_w", io_point_w, 256);
    check("oob", io_out_oob, eoob);
    if (hold > 0) begin
      sx = io_point_x; sy = io_point_y; sz = io_point_z; sw = io_point_w; so = io_out_oob;
      stable_ok = 1;
      io_in_valid = 1'b1;
      io_pixel_x = 16'd1; io_pixel_y = 16'd1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); #1;
        if (!io_out_valid || io_in_ready || io_point_x != sx || io_point_y != sy ||
            io_point_z != sz || io_point_w != sw || io_out_oob != so)
          stable_ok = 0;
      end
      io_in_valid = 1'b0;
      check("stall_stable", stable_ok, 1);
    end
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
    check("out_valid_drop", io_out_valid, 0);
    check("in_ready_back", io_in_ready, 1);
  endtask

  typedef struct {
    int x, y, d;
    int ex, ey;
    bit oob;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{x:320, y:240, d:0,    ex:0,    ey:0,    oob:0};
    vecs[1] = '{x:0,   y:0,   d:-100, ex:-256, ey:256,  oob:0};
`ifdef DENORM_ROUND_EN
    vecs[2] = '{x:639, y:479, d:7,    ex:255,  ey:-255, oob:0};
    vecs[3] = '{x:100, y:50,  d:33,   ex:-176, ey:203,  oob:0};
`else
    vecs[2] = '{x:639, y:479, d:7,    ex:255,  ey:-254, oob:0};
    vecs[3] = '{x:100, y:50,  d:33,   ex:-176, ey:202,  oob:0};
`endif
    vecs[4] = '{x:480, y:120, d:-1,   ex:128,  ey:128,  oob:0};
    vecs[5] = '{x:700, y:10,  d:500,  ex:304,  ey:245,  oob:1};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_in_ready", io_in_ready, 1);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_point_x", io_point_x, 0);
    check("rst_point_y", io_point_y, 0);
    check("rst_point_z", io_point_z, 0);
    check("rst_point_w", io_point_w, 0);
    check("rst_oob", io_out_oob, 0);

    for (int i = 0; i < 6; i++)
      run(vecs[i].x, vecs[i].y, vecs[i].d, 16'(vecs[i].ex), 16'(vecs[i].ey),
          vecs[i].oob, (i == 3) ? 20 : 0);

    // Reset in the middle of the X divide abandons the request.
    begin
      int seen;
      io_pixel_x = 16'd100; io_pixel_y = 16'd50; io_depth = 16'd9;
      io_in_valid = 1'b1;
      @(posedge clock); #1;
      io_in_valid = 1'b0;
      repeat (10) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("midrst_in_ready", io_in_ready, 1);
      check("midrst_out_valid", io_out_valid, 0);
      check("midrst_point_x", io_point_x, 0);
      check("midrst_point_y", io_point_y, 0);
      check("midrst_point_z", io_point_z, 0);
      check("midrst_point_w", io_point_w, 0);
      check("midrst_oob", io_out_oob, 0);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clock); #1;
        if (io_out_valid) seen++;
      end
      check("midrst_no_valid", seen, 0);
    end

    // Random requests: mostly on screen, some anywhere in the 16-bit range.
    for (int i = 0; i < 30; i++) begin
      int x, y, d;
      if (i % 4 == 3) begin
        x = int'($urandom_range(0, 65535));
        y = int'($urandom_range(0, 65535));
      end else begin
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
      end
      d = int'($urandom_range(0, 65535)) - 32768;
      run(x, y, d, model_axis(x - 320, 320), model_axis(240 - y, 240),
          (x >= 640) || (y >= 480), (i % 10 == 0) ? 3 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
